// File: rtl/uart_cmd_sequencer.sv
// UART hex command parser driving an SDRAM request port; request one cycle after the last nibble, one reply byte per free tx slot.
// Waits on tx_busy; CMD_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on outstanding requests.
module uart_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] addr,
    output logic [15:0] wr_data,
    output logic        wr_req,
    output logic        rd_req,
    input  logic        wr_done,
    input  logic        rd_ready,
    input  logic [15:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        cmd_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_REQ_WR = 3'd3;
    localparam logic [2:0] S_REQ_RD = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [1:0] RK_WR  = 2'd0;
    localparam logic [1:0] RK_RD  = 2'd1;
    localparam logic [1:0] RK_ERR = 2'd2;
    localparam logic [1:0] RK_TO  = 2'd3;

    logic [2:0]  state;
    logic        is_wr;
    logic [2:0]  nib_cnt;
    logic [23:0] addr_sh;
    logic [15:0] data_sh;
    logic [15:0] rd_buf;
    logic [1:0]  resp_kind;
    logic [2:0]  resp_idx;
    logic [7:0]  resp_byte;
    logic        resp_last;
    logic [4:0]  rx_hex;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // {valid, nibble}
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign rx_hex = hex_decode(rx_data);

    always_comb begin
        resp_byte = 8'h0A;
        case (resp_kind)
            RK_RD: begin
                case (resp_idx)
                    3'd0:    resp_byte = hex_char(rd_buf[15:12]);
                    3'd1:    resp_byte = hex_char(rd_buf[11:8]);
                    3'd2:    resp_byte = hex_char(rd_buf[7:4]);
                    3'd3:    resp_byte = hex_char(rd_buf[3:0]);
                    default: resp_byte = 8'h0A;
                endcase
            end
            RK_WR:   if (resp_idx == 3'd0) resp_byte = 8'h4B;
            RK_ERR:  if (resp_idx == 3'd0) resp_byte = 8'h3F;
            default: if (resp_idx == 3'd0) resp_byte = 8'h21;
        endcase
    end

    assign resp_last = (resp_kind == RK_RD) ? (resp_idx == 3'd4) : (resp_idx == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            is_wr     <= 1'b0;
            nib_cnt   <= 3'd0;
            addr_sh   <= 24'd0;
            data_sh   <= 16'd0;
            rd_buf    <= 16'd0;
            resp_kind <= RK_WR;
            resp_idx  <= 3'd0;
            addr      <= 24'd0;
            wr_data   <= 16'd0;
            wr_req    <= 1'b0;
            rd_req    <= 1'b0;
            tx_data   <= 8'd0;
            tx_send   <= 1'b0;
            cmd_err   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            tx_send <= 1'b0;
            cmd_err <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h57 || rx_data == 8'h77 ||
                            rx_data == 8'h52 || rx_data == 8'h72) begin
                            state   <= S_ADDR;
                            is_wr   <= (rx_data == 8'h57 || rx_data == 8'h77);
                            nib_cnt <= 3'd0;
                            addr_sh <= 24'd0;
                            data_sh <= 16'd0;
                        end else if (!(rx_data == 8'h0D || rx_data == 8'h0A || rx_data == 8'h20)) begin
                            state   <= S_ERR;
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        if (rx_hex[4]) begin
                            addr_sh <= {addr_sh[19:0], rx_hex[3:0]};
                            if (nib_cnt == 3'd5) begin
                                nib_cnt <= 3'd0;
                                if (is_wr) begin
                                    state <= S_DATA;
                                end else begin
                                    state  <= S_REQ_RD;
                                    addr   <= {addr_sh[19:0], rx_hex[3:0]};
                                    rd_req <= 1'b1;
                                end
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end else begin
                            state   <= S_ERR;
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        if (rx_hex[4]) begin
                            data_sh <= {data_sh[11:0], rx_hex[3:0]};
                            if (nib_cnt == 3'd3) begin
                                nib_cnt <= 3'd0;
                                state   <= S_REQ_WR;
                                addr    <= addr_sh;
                                wr_data <= {data_sh[11:0], rx_hex[3:0]};
                                wr_req  <= 1'b1;
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end else begin
                            state   <= S_ERR;
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_REQ_WR: begin
                    if (wr_done) begin
                        wr_req    <= 1'b0;
                        resp_kind <= RK_WR;
                        resp_idx  <= 3'd0;
                        state     <= S_RESP;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        wr_req    <= 1'b0;
                        cmd_err   <= 1'b1;
                        resp_kind <= RK_TO;
                        resp_idx  <= 3'd0;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_REQ_RD: begin
                    if (rd_ready) begin
                        rd_req    <= 1'b0;
                        rd_buf    <= rd_data;
                        resp_kind <= RK_RD;
                        resp_idx  <= 3'd0;
                        state     <= S_RESP;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        rd_req    <= 1'b0;
                        cmd_err   <= 1'b1;
                        resp_kind <= RK_TO;
                        resp_idx  <= 3'd0;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    // tx_send here is last cycle's strobe, giving the transmitter a cycle to raise busy
                    if (!tx_busy && !tx_send) begin
                        tx_data <= resp_byte;
                        tx_send <= 1'b1;
                        if (resp_last)
                            state <= S_IDLE;
                        else
                            resp_idx <= resp_idx + 3'd1;
                    end
                end
                S_ERR: begin
                    resp_kind <= RK_ERR;
                    resp_idx  <= 3'd0;
                    state     <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: expected tx bytes queued at stimulus time, checked by a tx monitor.
module tb_uart_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] addr;
    logic [15:0] wr_data;
    logic        wr_req;
    logic        rd_req;
    logic        wr_done;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        cmd_err;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int exp_err = 0;
    logic force_busy = 1'b0;
    logic [7:0] exp_q[$];

    uart_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .addr(addr), .wr_data(wr_data), .wr_req(wr_req), .rd_req(rd_req),
        .wr_done(wr_done), .rd_ready(rd_ready), .rd_data(rd_data),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .cmd_err(cmd_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_wr_req"}, wr_req, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_send"}, tx_send, 0);
        chk({tag, "_cmd_err"}, cmd_err, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_left"}, exp_q.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_rd_ready(input logic [15:0] d);
        rd_data  = d;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        rd_data  = 16'h0;
    endtask

    // tx monitor plus a transmitter model that stays busy for 3 cycles after each byte
    initial begin
        int   busy_cnt = 0;
        logic prev_err = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send) begin
                chk("tx_send_while_busy", tx_busy, 0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("FAIL tx_byte actual=%0h required=%0h", tx_data, e);
                    end
                end
            end
            if (cmd_err) begin
                err_pulses++;
                chk("cmd_err_single_cycle", prev_err, 0);
            end
            prev_err = cmd_err;
            if (tx_send) busy_cnt = 3;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = force_busy || (busy_cnt > 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_data = 8'h0; rx_valid = 1'b0;
        wr_done = 1'b0; rd_ready = 1'b0; rd_data = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // write with wr_done three cycles after wr_req rises
        push_str("K\n");
        send_str("W0012345A5A");
        for (int i = 0; i < 3; i++) begin
            chk("wr_req_held", wr_req, 1);
            chk("wr_rd_req_low", rd_req, 0);
            chk("wr_addr", addr, 24'h001234);
            chk("wr_data", wr_data, 16'h5A5A);
            @(negedge clk);
        end
        wr_done = 1'b1;
        rx_data = 8'h52; rx_valid = 1'b1;
        @(negedge clk);
        wr_done = 1'b0; rx_valid = 1'b0;
        chk("wr_req_drop", wr_req, 0);
        drain("write");

        // lowercase read, stray rx byte coincident with rd_ready
        push_str("BEEF\n");
        send_str("r00abcd");
        chk("rd_req_high", rd_req, 1);
        chk("rd_wr_req_low", wr_req, 0);
        chk("rd_addr", addr, 24'h00ABCD);
        @(negedge clk);
        rx_data = 8'h58; rx_valid = 1'b1;
        pulse_rd_ready(16'hBEEF);
        rx_valid = 1'b0;
        chk("rd_req_drop", rd_req, 0);
        drain("read");

        // bad hex digit aborts, next command still runs
        push_str("?\n");
        send_str("W00");
        send_byte("G");
        exp_err++;
        chk("err_pulse_on_G", cmd_err, 1);
        chk("err_no_wr_req", wr_req, 0);
        drain("err");
        push_str("1234\n");
        send_str("R000001");
        chk("after_err_addr", addr, 24'h000001);
        chk("after_err_rd_req", rd_req, 1);
        pulse_rd_ready(16'h1234);
        drain("after_err");

        // stray completion strobes in IDLE do nothing
        wr_done = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        wr_done = 1'b0; rd_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("stray_strobe_wr_req", wr_req, 0);

        // transmitter busy for 100 cycles across the read response
        push_str("A0C9\n");
        send_str("R0000FF");
        force_busy = 1'b1;
        @(negedge clk);
        pulse_rd_ready(16'hA0C9);
        repeat (100) @(negedge clk);
        chk("busy_none_sent", exp_q.size(), 5);
        force_busy = 1'b0;
        drain("busy");

        // reset while waiting for read data
        send_str("R000010");
        chk("rst_rdreq_pre", rd_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_in_req_rd");
        rst = 1'b0;
        @(negedge clk);
        pulse_rd_ready(16'h5555);
        repeat (20) @(negedge clk);
        chk("rst_req_rd_no_rdreq", rd_req, 0);

        // reset while response stalled on busy
        send_str("R000020");
        force_busy = 1'b1;
        @(negedge clk);
        pulse_rd_ready(16'h7777);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_in_resp");
        rst = 1'b0;
        force_busy = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_resp_tx_data", tx_data, 0);

`ifdef CMD_TIMEOUT_EN
        begin
            int hi = 0;
            push_str("!\n");
            send_str("W0000011234");
            exp_err++;
            while (wr_req && hi < 100) begin
                hi++;
                @(negedge clk);
            end
            chk("timeout_wr_req_cycles", hi, 16);
            chk("timeout_cmd_err", cmd_err, 1);
            drain("timeout");
        end
`endif

        chk("cmd_err_count", err_pulses, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the max cycles to wait for wr_done/rd_ready.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  received UART byte.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port addr  output  24  SDRAM word address.
REQ-007 SHALL have port wr_data  output  16  SDRAM write data.
REQ-008 SHALL have port wr_req  output  1  write request, level-held.
REQ-009 SHALL have port rd_req  output  1  read request, level-held.
REQ-010 SHALL have port wr_done  input  1  one-cycle write-complete strobe.
REQ-011 SHALL have port rd_ready  input  1  one-cycle strobe qualifying rd_data.
REQ-012 SHALL have port rd_data  input  16  SDRAM read data.
REQ-013 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-014 SHALL have port tx_send  output  1  one-cycle transmit strobe.
REQ-015 SHALL have port tx_busy  input  1  transmitter busy.
REQ-016 SHALL have port cmd_err  output  1  one-cycle pulse on any command error.

Function
REQ-017 SHALL parse ASCII commands: 'W' + 6 hex addr + 4 hex data (write); 'R' + 6 hex addr (read); hex = 0-9, A-F, a-f; MSB nibble first.
REQ-018 SHALL implement states IDLE, ADDR, DATA, REQ_WR, REQ_RD, RESP, ERR.
REQ-019 IDLE: 'W'/'R' (either case) -> ADDR with nibble count cleared; CR (0x0D), LF (0x0A), space ignored; any other byte -> ERR.
REQ-020 ADDR: each hex byte shifts into a 24-bit shadow; after 6th nibble -> DATA (write) or REQ_RD (read); non-hex -> ERR.
REQ-021 DATA: each hex byte shifts into a 16-bit shadow; after 4th nibble -> REQ_WR; non-hex -> ERR.
REQ-022 addr and wr_data SHALL update from shadows on entry to REQ_WR/REQ_RD and stay stable while wr_req/rd_req high.
REQ-023 wr_req (rd_req) SHALL assert the cycle after the final nibble is accepted and hold until the cycle wr_done (rd_ready) is sampled high, deasserting the next cycle; never both high.
REQ-024 On rd_ready SHALL capture rd_data; response = 4 uppercase hex chars of rd_data MSB first then LF (5 bytes); write response = 'K' then LF.
REQ-025 RESP: tx_send pulses only when tx_busy=0 and no tx_send in the previous cycle; one byte per pulse; after last byte -> IDLE.
REQ-026 ERR: cmd_err pulses one cycle; response '?' then LF; -> IDLE.
REQ-027 rx_valid outside IDLE/ADDR/DATA SHALL be dropped with no state effect, including when coincident with wr_done/rd_ready.
REQ-028 Strobes wr_done/rd_ready outside the matching REQ state SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE next cycle, aborting any command/response, from any state.
REQ-030 Reset values: addr=0, wr_data=0, wr_req=0, rd_req=0, tx_data=0, tx_send=0, cmd_err=0, shadows and counters 0.

Configuration
REQ-031 Macro CMD_TIMEOUT_EN defined: a counter runs in REQ_WR/REQ_RD; on reaching TIMEOUT_CYCLES without completion, deassert request, pulse cmd_err, respond '!' then LF, -> IDLE.
REQ-032 Macro CMD_TIMEOUT_EN undefined: no counter; REQ states wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-033 Bytes "W0012345A5A", wr_done 3 cycles after wr_req -> addr=0x001234, wr_data=0x5A5A, wr_req high exactly until wr_done, tx bytes 'K',0x0A.
REQ-034 "r00abcd", rd_ready with rd_data=0xBEEF -> addr=0x00ABCD, rd_req only, tx bytes "BEEF",0x0A.
REQ-035 "W00G" -> cmd_err pulse on 'G', tx '?',0x0A, no wr_req; following "R000001" processed normally.
REQ-036 tx_busy held high 100 cycles during read response -> no tx_send while busy, all 5 bytes delivered in order, none duplicated.
REQ-037 rst during REQ_RD and during RESP -> all outputs at reset values next cycle; later rd_ready ignored.
REQ-038 CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, no wr_done -> wr_req drops after 16 cycles, cmd_err pulse, tx '!',0x0A.
